// File: rtl/uart_link_arbiter.sv
// rtl/uart_link_arbiter.sv - two-requester byte arbiter feeding one UART TX, with deferred line-config apply and TX watchdog.
module uart_link_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       i_Clock,
  input  logic       rst,
  input  logic       i_Req0,
  input  logic       i_Req1,
  input  logic [7:0] i_Data0,
  input  logic [7:0] i_Data1,
  output logic       o_Ack0,
  output logic       o_Ack1,
  input  logic       i_Cfg_Wr,
  input  logic [4:0] i_Cfg_Clks_Per_Bit,
  input  logic       i_Cfg_Pen,
  input  logic       i_Cfg_Eps,
  output logic       o_Cfg_Pending,
  output logic       o_Cfg_Err,
  output logic [4:0] o_Clks_Per_Bit,
  output logic       o_Pen,
  output logic       o_Eps,
  input  logic       i_Rx_Busy,
  output logic       o_Tx_Start,
  output logic [7:0] o_Tx_Byte,
  input  logic       i_Tx_Done,
  output logic       o_Tx_Timeout,
  output logic       o_Arb_Busy
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic        last_served;
  logic        winner;
  logic [4:0]  pend_clks;
  logic        pend_pen, pend_eps;

  logic cfg_bad, cfg_ok, apply, grant, pick1, done_hit, to_hit;

  always_comb begin
    cfg_bad  = i_Cfg_Wr && (i_Cfg_Clks_Per_Bit < 5'd4);
    cfg_ok   = i_Cfg_Wr && !cfg_bad;
    apply    = o_Cfg_Pending && (state == IDLE) && !i_Rx_Busy;
    // A pending config blocks grants, so it always gets an idle window.
    grant    = (state == IDLE) && !o_Cfg_Pending && (i_Req0 || i_Req1);
    pick1    = i_Req1 && (!i_Req0 || !last_served);
    done_hit = (state == WAIT_DONE) && i_Tx_Done;
    to_hit   = (state == WAIT_DONE) && !i_Tx_Done && (cnt == LAST_CNT);
    state_nxt = state;
    case (state)
      IDLE:      if (grant) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_DONE;
      WAIT_DONE: if (done_hit || to_hit) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge i_Clock) begin
    if (rst) begin
      cnt            <= 16'd0;
      last_served    <= 1'b1;
      winner         <= 1'b0;
      pend_clks      <= 5'd0;
      pend_pen       <= 1'b0;
      pend_eps       <= 1'b0;
      o_Ack0         <= 1'b0;
      o_Ack1         <= 1'b0;
      o_Cfg_Pending  <= 1'b0;
      o_Cfg_Err      <= 1'b0;
      o_Clks_Per_Bit <= 5'd16;
      o_Pen          <= 1'b0;
      o_Eps          <= 1'b0;
      o_Tx_Start     <= 1'b0;
      o_Tx_Byte      <= 8'd0;
      o_Tx_Timeout   <= 1'b0;
      o_Arb_Busy     <= 1'b0;
    end else begin
      cnt          <= (state == WAIT_DONE) ? cnt + 16'd1 : 16'd0;
      o_Tx_Start   <= grant;
      o_Ack0       <= grant && !pick1;
      o_Ack1       <= grant && pick1;
      o_Tx_Timeout <= to_hit;
      o_Arb_Busy   <= (state_nxt != IDLE);
      o_Cfg_Err    <= cfg_bad;
      if (grant) begin
        winner    <= pick1;
        o_Tx_Byte <= pick1 ? i_Data1 : i_Data0;
      end
      if (done_hit || to_hit) last_served <= winner;
      if (apply) begin
        o_Clks_Per_Bit <= pend_clks;
        o_Pen          <= pend_pen;
        o_Eps          <= pend_eps;
      end
      // A write landing on the apply edge becomes the next pending value.
      if (cfg_ok) begin
        pend_clks     <= i_Cfg_Clks_Per_Bit;
        pend_pen      <= i_Cfg_Pen;
        pend_eps      <= i_Cfg_Eps;
        o_Cfg_Pending <= 1'b1;
      end else if (apply) begin
        o_Cfg_Pending <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_link_arbiter.md
UART_LINK_ARBITER -- requirements
Module: uart_link_arbiter

Interface
REQ-001 The parameter TIMEOUT_CYCLES SHALL default to 4096; it sets the WAIT_DONE watchdog limit in clocks and SHALL be less than 65536.
REQ-002 The port list SHALL be as follows; one clock, reset synchronous and active-high.
- i_Clock  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- i_Req0 / i_Req1  in  1  requester 0/1 byte request; held high until acked.
- i_Data0 / i_Data1  in  8  requester 0/1 byte; stable while request high.
- o_Ack0 / o_Ack1  out  1  one-cycle pulse; byte captured.
- i_Cfg_Wr  in  1  one-cycle config write strobe.
- i_Cfg_Clks_Per_Bit  in  5  requested clocks per bit.
- i_Cfg_Pen / i_Cfg_Eps  in  1  requested parity enable / even-parity select.
- o_Cfg_Pending  out  1  config written, not yet applied.
- o_Cfg_Err  out  1  one-cycle pulse; config write rejected.
- o_Clks_Per_Bit  out  5  applied clocks per bit, to the UART RX and TX.
- o_Pen / o_Eps  out  1  applied parity enable / select, to the UART RX and TX.
- i_Rx_Busy  in  1  UART receiver busy.
- o_Tx_Start  out  1  one-cycle transmitter launch pulse.
- o_Tx_Byte  out  8  byte to transmit; valid while o_Tx_Start high.
- i_Tx_Done  in  1  transmitter frame-complete pulse.
- o_Tx_Timeout  out  1  one-cycle pulse; watchdog expired.
- o_Arb_Busy  out  1  high whenever state != IDLE.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, LAUNCH and WAIT_DONE; all outputs SHALL be registered.
REQ-004 In IDLE with no config apply and any request high, the arbiter SHALL select a winner and move to LAUNCH on the next edge.
REQ-005 With both requests high, the winner SHALL be the requester not served last; after reset, requester 0 SHALL win.
REQ-006 In LAUNCH, o_Tx_Start SHALL be 1 for exactly one cycle, with o_Tx_Byte equal to the winner's data captured at the grant edge.
- The winner's o_Ack SHALL pulse in that same cycle.
- The FSM SHALL go to WAIT_DONE on the next edge.
REQ-007 Request-to-start latency SHALL be 1 clock: request sampled at edge n gives o_Tx_Start high in cycle n+1.
REQ-008 In WAIT_DONE, a 16-bit counter SHALL start at 0 and increment each cycle.
- i_Tx_Done=1 SHALL return the FSM to IDLE and update the last-served pointer.
- If the counter reaches TIMEOUT_CYCLES-1 without i_Tx_Done, o_Tx_Timeout SHALL pulse one cycle, the FSM SHALL return to IDLE and the last-served pointer SHALL still update.
REQ-009 If i_Tx_Done and the timeout occur in the same cycle, i_Tx_Done SHALL win and no timeout pulse SHALL be issued.
REQ-010 i_Tx_Done outside WAIT_DONE SHALL be ignored.
REQ-011 A request dropped before its ack SHALL be withdrawn without error; a byte already captured SHALL still be transmitted.
REQ-012 i_Cfg_Wr with i_Cfg_Clks_Per_Bit < 4 SHALL be rejected: o_Cfg_Err pulses one cycle and pending state is unchanged.
REQ-013 An accepted i_Cfg_Wr SHALL latch all three config fields into a pending register and set o_Cfg_Pending.
- A later accepted write SHALL overwrite the pending values.
REQ-014 The pending config SHALL apply on the first edge where the state is IDLE and i_Rx_Busy=0.
- On that edge, o_Clks_Per_Bit, o_Pen and o_Eps SHALL update and o_Cfg_Pending SHALL clear.
REQ-015 While o_Cfg_Pending=1, no new grant SHALL be issued, so a config cannot be starved by requesters.
- On the apply edge itself, any request SHALL wait for the following cycle.
REQ-016 An accepted i_Cfg_Wr in the same cycle as an apply SHALL become the new pending value, with o_Cfg_Pending staying 1.
REQ-017 Applied config SHALL never change while state != IDLE or while i_Rx_Busy=1.

Reset
REQ-018 rst=1 at a rising edge SHALL force the following, overriding all other inputs that cycle including mid-frame:
- state IDLE, counter 0, pending cleared, last-served pointer set so requester 0 wins next;
- o_Clks_Per_Bit=16, o_Pen=0, o_Eps=0;
- all pulse outputs, o_Cfg_Pending and o_Arb_Busy = 0.
REQ-019 A request still high after reset release SHALL be re-arbitrated normally.

Verification
REQ-020 Both requests rise together (i_Data0=0x55, i_Data1=0xA3), i_Tx_Done returned after 200 clocks each frame -> 0x55 sent first with o_Ack0, then 0xA3 with o_Ack1, each o_Tx_Start exactly 1 cycle wide.
REQ-021 Only i_Req0 held high for 3 frames while i_Req1 rises at frame 2 -> grant order 0, 1, 0.
REQ-022 i_Cfg_Wr (8, pen=1, eps=1) issued mid-frame with i_Rx_Busy=1 until 50 clocks after i_Tx_Done -> outputs stay 16/0/0 until i_Rx_Busy falls, then 8/1/1 on that edge, with no grant in between.
REQ-023 i_Cfg_Wr with clks=3 -> o_Cfg_Err pulses once, o_Cfg_Pending stays 0, applied config unchanged.
REQ-024 TIMEOUT_CYCLES=64, i_Tx_Done never asserted -> o_Tx_Timeout pulses 64 clocks after entering WAIT_DONE, FSM returns to IDLE, other requester served next.
REQ-025 rst asserted during WAIT_DONE with config pending -> next cycle: o_Arb_Busy=0, o_Cfg_Pending=0, outputs 16/0/0, no o_Tx_Timeout.
